// File: rtl/biriscv_iter_divider_pkg.sv
// rtl/biriscv_iter_divider_pkg.sv - shared encodings and constants for the iterative divider
package biriscv_iter_divider_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/biriscv_div_step.sv
// rtl/biriscv_div_step.sv - one combinational radix-2 restoring division iteration
module biriscv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] q_o
);

    logic [W:0] rem_shift;
    logic [W:0] diff;

    // The shifted remainder keeps its carry-out bit so divisors above 2^(W-1) stay exact.
    always_comb begin
        rem_shift = {rem_i, q_i[W-1]};
        diff      = rem_shift - {1'b0, div_i};
        if (!diff[W]) begin
            rem_o = diff[W-1:0];
            q_o   = {q_i[W-2:0], 1'b1};
        end else begin
            rem_o = rem_shift[W-1:0];
            q_o   = {q_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/biriscv_iter_divider.sv
// rtl/biriscv_iter_divider.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit
module biriscv_iter_divider
    import biriscv_iter_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;

    logic            accept;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic            overflow;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN-1:0] step_rem, step_q;

    biriscv_div_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .q_i   (q_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        is_signed = (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg     = is_signed && operand_a_i[XLEN-1];
        b_neg     = is_signed && operand_b_i[XLEN-1];
        a_abs     = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
        b_abs     = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
        overflow  = is_signed && (operand_a_i == INT_MIN) && (operand_b_i == '1);
        accept    = (state_q == ST_IDLE) && valid_i && !flush_i;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        rem_d    = rem_q;
        div_d    = div_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_rem_d = op_i[1];
                    if (operand_b_i == '0) begin
                        result_d = op_i[1] ? operand_a_i : DIV_BY_ZERO_Q;
                        state_d  = ST_DONE;
                    end else if (overflow) begin
                        result_d = op_i[1] ? '0 : INT_MIN;
                        state_d  = ST_DONE;
                    end else begin
                        q_d     = a_abs;
                        rem_d   = '0;
                        div_d   = b_abs;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = 5'd31;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    q_d   = step_q;
                    rem_d = step_rem;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        // Sign fix is folded into the final iteration so DONE only presents.
                        result_d = is_rem_q ? negate_if(step_rem, neg_r_q)
                                            : negate_if(step_q, neg_q_q);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            result_q <= result_d;
            is_rem_q <= is_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE) && !flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_biriscv_iter_divider.sv
// tb/tb_biriscv_iter_divider.sv - self-checking bench for biriscv_iter_divider
module tb_biriscv_iter_divider;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic [31:0] result_o;

    int total = 0;
    int bad = 0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    biriscv_iter_divider dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op == DIV || op == REM) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? sa % sb : sa / sb;
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 0) return 1;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at a negedge with ready_o high; returns at the negedge after the pulse.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic [31:0] res;
        lat = 99;
        res = 'x;
        check({name, "_ready_at_accept"}, {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        op_i = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        op_i = 2'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = c;
                res = result_o;
                break;
            end
            if (ready_o) begin
                check({name, "_ready_while_busy"}, {31'd0, ready_o}, 32'd0);
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, res, exp_res);
        @(negedge clk_i);
        check({name, "_ready_after"}, {31'd0, ready_o}, 32'd1);
        check({name, "_valid_single"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        vecs.push_back('{DIVU, 32'd100, 32'd7, 32'd14, 33});
        vecs.push_back('{REMU, 32'd100, 32'd7, 32'd2, 33});
        vecs.push_back('{DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33});
        vecs.push_back('{REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33});
        vecs.push_back('{DIV,  32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33});
        vecs.push_back('{DIV,  32'h1234, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{REMU, 32'h1234, 32'd0, 32'h1234, 1});
        vecs.push_back('{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1});
        vecs.push_back('{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33});
        vecs.push_back('{REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33});
        vecs.push_back('{REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33});

        #1;
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom | 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b, ref_result(op, a, b),
                   ref_latency(op, a, b));
        end

        // Flush in RUN at T+10, then a new operation accepted at T+11.
        valid_i = 1'b1;
        op_i = DIVU;
        operand_a_i = 32'd1000;
        operand_b_i = 32'd3;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            check("flush_no_valid", {31'd0, valid_o}, 32'd0);
            check("flush_busy", {31'd0, ready_o}, 32'd0);
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_ready_t11", {31'd0, ready_o}, 32'd1);
        check("flush_valid_t11", {31'd0, valid_o}, 32'd0);
        run_op("after_flush", DIVU, 32'd9, 32'd2, 32'd4, 33);

        // Flush and valid together in IDLE must not start anything.
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i = DIVU;
        operand_a_i = 32'd50;
        operand_b_i = 32'd5;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("flush_idle_ready", {31'd0, ready_o}, 32'd1);
            check("flush_idle_valid", {31'd0, valid_o}, 32'd0);
        end

        // Asynchronous reset in the middle of cycle T+5.
        valid_i = 1'b1;
        op_i = DIV;
        operand_a_i = 32'd12345;
        operand_b_i = 32'd11;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, ready_o}, 32'd1);
        check("async_rst_valid", {31'd0, valid_o}, 32'd0);
        check("async_rst_result", result_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_valid", {31'd0, valid_o}, 32'd0);
        run_op("post_rst", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
